// File: rtl/ripple_pkg.sv
// rtl/ripple_pkg.sv - shared state encoding and sizing helpers for the sequential ripple adder
package ripple_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Bits needed to count value distinct indices; never less than one so idx always has a bit
    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r++;
            v = v >> 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

    // Legal configurations: at least one bit per chunk and a whole number of chunks
    function automatic bit cfg_ok(input int width, input int chunk);
        return (chunk >= 1) && (width >= chunk) && ((width % chunk) == 0);
    endfunction

endpackage

// File: rtl/ripple_chunk.sv
// rtl/ripple_chunk.sv - combinational CHUNK-bit ripple of full adders with carry-into-MSB tap
module ripple_chunk
    import ripple_pkg::*;
#(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] sum,
    output logic             cout,
    output logic             cmsb
);

    logic [CHUNK:0] c;

    // Full-adder chain; c[i] is the carry into bit i
    always_comb begin
        c    = '0;
        sum  = '0;
        c[0] = cin;
        for (int i = 0; i < CHUNK; i++) begin
            sum[i]   = a[i] ^ b[i] ^ c[i];
            c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
    end

    assign cout = c[CHUNK];
    assign cmsb = c[CHUNK - 1];

endmodule

// File: rtl/ripple_seq_adder.sv
// rtl/ripple_seq_adder.sv - multi-cycle WIDTH-bit adder, CHUNK bits per clock; optional ovf via RIPPLE_SEQ_ADDER_OVF_EN
module ripple_seq_adder
    import ripple_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef RIPPLE_SEQ_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int NCHUNK = (CHUNK >= 1) ? (WIDTH / CHUNK) : 1;
    localparam int IDXW   = clog2(NCHUNK);
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCHUNK - 1);

    if (!cfg_ok(WIDTH, CHUNK)) begin : g_cfg_bad
        $error("ripple_seq_adder: WIDTH must be a positive multiple of CHUNK");
    end

    state_t           state;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             carry_q;
    logic [IDXW-1:0]  idx_q;

    logic [CHUNK-1:0] a_chunk;
    logic [CHUNK-1:0] b_chunk;
    logic [CHUNK-1:0] chunk_sum;
    logic             chunk_cout;
    logic             chunk_cmsb;

    // Handshake flags come from registered state only (plus reset for in_ready)
    assign in_ready  = (state == IDLE) && rst_n;
    assign out_valid = (state == DONE);

    // Select the operand slice for the chunk currently being added
    always_comb begin
        a_chunk = '0;
        b_chunk = '0;
        for (int i = 0; i < NCHUNK; i++) begin
            if (idx_q == IDXW'(i)) begin
                a_chunk = a_q[i*CHUNK +: CHUNK];
                b_chunk = b_q[i*CHUNK +: CHUNK];
            end
        end
    end

    ripple_chunk #(
        .CHUNK (CHUNK)
    ) u_chunk (
        .a    (a_chunk),
        .b    (b_chunk),
        .cin  (carry_q),
        .sum  (chunk_sum),
        .cout (chunk_cout),
        .cmsb (chunk_cmsb)
    );

`ifndef RIPPLE_SEQ_ADDER_OVF_EN
    logic unused_cmsb;
    assign unused_cmsb = chunk_cmsb;
`endif

    // Control FSM and result registers: accept, one chunk per RUN edge, hold in DONE
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            idx_q   <= '0;
            sum     <= '0;
            cout    <= 1'b0;
`ifdef RIPPLE_SEQ_ADDER_OVF_EN
            ovf     <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_q     <= a;
                        b_q     <= b;
                        carry_q <= cin;
                        idx_q   <= '0;
                        state   <= RUN;
                    end
                end
                RUN: begin
                    for (int i = 0; i < NCHUNK; i++) begin
                        if (idx_q == IDXW'(i)) begin
                            sum[i*CHUNK +: CHUNK] <= chunk_sum;
                        end
                    end
                    carry_q <= chunk_cout;
                    if (idx_q == LAST_IDX) begin
                        cout  <= chunk_cout;
`ifdef RIPPLE_SEQ_ADDER_OVF_EN
                        ovf   <= chunk_cmsb ^ chunk_cout;
`endif
                        idx_q <= '0;
                        state <= DONE;
                    end else begin
                        idx_q <= idx_q + IDXW'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ripple_seq_adder.sv
// tb/tb_ripple_seq_adder.sv - directed and swept checks of ripple_seq_adder
module tb_ripple_seq_adder;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int passed = 0;
    int fails  = 0;
    int total  = 0;

    // WIDTH=16, CHUNK=4
    logic        iv = 0, ir, ov, orr = 1, ci = 0, co;
    logic [15:0] a16 = 0, b16 = 0, s16;
    // WIDTH=8, CHUNK=8
    logic        iv8 = 0, ir8, ov8, or8 = 1, ci8 = 0, co8;
    logic [7:0]  a8 = 0, b8 = 0, s8;
    // WIDTH=4, CHUNK=1
    logic        iv4 = 0, ir4, ov4, or4 = 1, ci4 = 0, co4;
    logic [3:0]  a4 = 0, b4 = 0, s4;
`ifdef RIPPLE_SEQ_ADDER_OVF_EN
    logic        ovf16, ovf8, ovf4;
`endif

    ripple_seq_adder #(.WIDTH(16), .CHUNK(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(iv), .in_ready(ir), .a(a16), .b(b16), .cin(ci),
        .out_valid(ov), .out_ready(orr), .sum(s16), .cout(co)
`ifdef RIPPLE_SEQ_ADDER_OVF_EN
        , .ovf(ovf16)
`endif
    );

    ripple_seq_adder #(.WIDTH(8), .CHUNK(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8), .cin(ci8),
        .out_valid(ov8), .out_ready(or8), .sum(s8), .cout(co8)
`ifdef RIPPLE_SEQ_ADDER_OVF_EN
        , .ovf(ovf8)
`endif
    );

    ripple_seq_adder #(.WIDTH(4), .CHUNK(1)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv4), .in_ready(ir4), .a(a4), .b(b4), .cin(ci4),
        .out_valid(ov4), .out_ready(or4), .sum(s4), .cout(co4)
`ifdef RIPPLE_SEQ_ADDER_OVF_EN
        , .ovf(ovf4)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Accept one operation on the 16-bit DUT, check latency and result; leaves it in DONE
    task automatic op16(input string tag, input logic [15:0] x, input logic [15:0] y,
                        input logic c, input logic [15:0] es, input logic ec);
        int n;
        n = 0;
        while (!ir && n < 50) begin tick(); n++; end
        chk({tag, ".in_ready"}, 32'(ir), 1);
        a16 = x; b16 = y; ci = c; iv = 1'b1;
        tick();
        iv = 1'b0; a16 = 16'hDEAD; b16 = 16'hBEEF; ci = 1'b1;
        n = 0;
        while (!ov && n < 50) begin tick(); n++; end
        chk({tag, ".latency"}, n, 4);
        chk({tag, ".sum"}, 32'(s16), 32'(es));
        chk({tag, ".cout"}, 32'(co), 32'(ec));
    endtask

    // Output handshake with out_ready high; in_ready must be back right after it
    task automatic drain16(input string tag);
        orr = 1'b1;
        tick();
        chk({tag, ".out_valid_drop"}, 32'(ov), 0);
        chk({tag, ".in_ready_back"}, 32'(ir), 1);
    endtask

    task automatic op8(input logic [7:0] x, input logic [7:0] y, input logic c);
        logic [8:0] e;
        logic       hs;
        int         n;
        e = 9'(x) + 9'(y) + 9'(c);
        n = 0;
        while (!ir8 && n < 50) begin tick(); n++; end
        chk("w8.in_ready", 32'(ir8), 1);
        a8 = x; b8 = y; ci8 = c; iv8 = 1'b1;
        tick();
        iv8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom); ci8 = 1'($urandom);
        n = 0;
        while (!ov8 && n < 50) begin or8 = 1'($urandom); tick(); n++; end
        chk("w8.latency", n, 1);
        hs = 1'b0; n = 0;
        while (!hs && n < 50) begin
            chk("w8.sum", 32'(s8), 32'(e[7:0]));
            chk("w8.cout", 32'(co8), 32'(e[8]));
            hs = 1'($urandom); or8 = hs; tick(); n++;
        end
        chk("w8.released", 32'(ov8), 0);
    endtask

    task automatic op4(input logic [3:0] x, input logic [3:0] y, input logic c);
        logic [4:0] e;
        logic       hs;
        int         n;
        e = 5'(x) + 5'(y) + 5'(c);
        n = 0;
        while (!ir4 && n < 50) begin tick(); n++; end
        chk("w4.in_ready", 32'(ir4), 1);
        a4 = x; b4 = y; ci4 = c; iv4 = 1'b1;
        tick();
        iv4 = 1'b0; a4 = 4'($urandom); b4 = 4'($urandom); ci4 = 1'($urandom);
        n = 0;
        while (!ov4 && n < 50) begin or4 = 1'($urandom); tick(); n++; end
        chk("w4.latency", n, 4);
        hs = 1'b0; n = 0;
        while (!hs && n < 50) begin
            chk("w4.sum", 32'(s4), 32'(e[3:0]));
            chk("w4.cout", 32'(co4), 32'(e[4]));
            hs = 1'($urandom); or4 = hs; tick(); n++;
        end
        chk("w4.released", 32'(ov4), 0);
    endtask

    initial begin
        // Reset state
        tick();
        tick();
        chk("rst.out_valid", 32'(ov), 0);
        chk("rst.sum", 32'(s16), 0);
        chk("rst.cout", 32'(co), 0);
        chk("rst.in_ready_low", 32'(ir), 0);
        rst_n = 1'b1;
        #1;
        chk("rst.in_ready_high", 32'(ir), 1);

        // Basic additions with the consumer always ready
        op16("basic", 16'h0005, 16'h000A, 1'b0, 16'h000F, 1'b0);
        drain16("basic");
        op16("carry_all", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1);
`ifdef RIPPLE_SEQ_ADDER_OVF_EN
        chk("carry_all.ovf", 32'(ovf16), 0);
`endif
        drain16("carry_all");
        op16("cin_only", 16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0);
        drain16("cin_only");
        op16("wrap_cin", 16'h8000, 16'h8000, 1'b1, 16'h0001, 1'b1);
        drain16("wrap_cin");
`ifdef RIPPLE_SEQ_ADDER_OVF_EN
        op16("ovf_pos", 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0);
        chk("ovf_pos.ovf", 32'(ovf16), 1);
        drain16("ovf_pos");
`endif

        // Backpressure: result held, a waiting request is not taken while DONE
        orr = 1'b0;
        op16("bp", 16'h1234, 16'h1111, 1'b0, 16'h2345, 1'b0);
        a16 = 16'h0001; b16 = 16'h0002; ci = 1'b0; iv = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("bp.hold_sum", 32'(s16), 32'h2345);
            chk("bp.hold_valid", 32'(ov), 1);
            chk("bp.busy_ready", 32'(ir), 0);
        end
        orr = 1'b1;
        tick();
        chk("bp.after_hs_ready", 32'(ir), 1);
        chk("bp.after_hs_valid", 32'(ov), 0);
        tick();
        iv = 1'b0;
        begin
            int n;
            n = 0;
            while (!ov && n < 50) begin tick(); n++; end
            chk("bp.second_latency", n, 4);
            chk("bp.second_sum", 32'(s16), 32'h0003);
        end
        tick();

        // Reset in the middle of RUN aborts the operation
        a16 = 16'hAAAA; b16 = 16'h5555; ci = 1'b0; iv = 1'b1;
        tick();
        iv = 1'b0;
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        chk("mid_rst.out_valid", 32'(ov), 0);
        chk("mid_rst.sum", 32'(s16), 0);
        chk("mid_rst.cout", 32'(co), 0);
        chk("mid_rst.in_ready", 32'(ir), 0);
        rst_n = 1'b1;
        #1;
        chk("mid_rst.in_ready_back", 32'(ir), 1);
        op16("post_rst", 16'h0101, 16'h0202, 1'b0, 16'h0303, 1'b0);
        drain16("post_rst");

        // Parameter sweeps against an a+b+cin model
        op8(8'hFF, 8'h00, 1'b1);
        op4(4'hF, 4'hF, 1'b1);
        for (int k = 0; k < 500; k++) begin
            op8(8'($urandom), 8'($urandom), 1'($urandom));
        end
        for (int k = 0; k < 500; k++) begin
            op4(4'($urandom), 4'($urandom), 1'($urandom));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
